// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - receiver state encoding and payload-width clamp shared by the uart_rx slice
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // A zero or oversized request means "full word".
    function automatic logic [5:0] clamp_bits(input logic [5:0] req, input int unsigned max_bits);
        if (req == 6'd0 || 32'(req) > max_bits) begin
            return 6'(max_bits);
        end
        return req;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the serial line, idles high out of reset
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - serial frame receiver (start, LSB-first payload, stop) with done/error strobes
// Optional UART_RX_SYNC_EN puts a two-flop synchroniser in front of the FSM.
module uart_rx
    import uart_pkg::*;
#(
    parameter int MAX_WORD_SIZE = 8,
    parameter int CLKS_PER_BIT  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx,
    input  logic [5:0]               rx_bits,
    output logic [MAX_WORD_SIZE-1:0] dout,
    output logic                     rx_done,
    output logic                     rx_err
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((HALF > 0) ? HALF - 1 : 0);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    rx_state_e                state_q, state_d;
    logic [CW-1:0]            clk_cnt_q, clk_cnt_d;
    logic [5:0]               bit_cnt_q, bit_cnt_d;
    logic [5:0]               nbits_q, nbits_d;
    logic [MAX_WORD_SIZE-1:0] shift_q, shift_d;
    logic [MAX_WORD_SIZE-1:0] dout_q, dout_d;
    logic                     rx_done_q, rx_done_d;
    logic                     rx_err_q, rx_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            nbits_q   <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            rx_done_q <= 1'b0;
            rx_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            nbits_q   <= nbits_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            rx_done_q <= rx_done_d;
            rx_err_q  <= rx_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        nbits_d   = nbits_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        rx_done_d = 1'b0;
        rx_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    nbits_d   = clamp_bits(rx_bits, MAX_WORD_SIZE);
                    shift_d   = '0;
                    // At one clock per bit the start bit has already been seen in full.
                    state_d   = (CLKS_PER_BIT == 1) ? ST_DATA : ST_START;
                end
            end
            ST_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    for (int i = 0; i < MAX_WORD_SIZE; i++) begin
                        if (bit_cnt_q == 6'(i)) begin
                            shift_d[i] = rx_s;
                        end
                    end
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == nbits_q - 6'd1) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        dout_d    = shift_q;
                        rx_done_d = 1'b1;
                    end else begin
                        rx_err_d  = 1'b1;
                    end
                    // Leaving now lets a back-to-back start bit be caught next cycle.
                    state_d = ST_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dout    = dout_q;
    assign rx_done = rx_done_q;
    assign rx_err  = rx_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized frame bench for uart_rx at 1 and 16 clocks per bit
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx1, rx16;
    logic [5:0] rx_bits1, rx_bits16;
    logic [7:0] dout1, dout16;
    logic       done1, err1, done16, err16;

    always #5 clk = ~clk;

    uart_rx #(.MAX_WORD_SIZE(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_bits(rx_bits1),
        .dout(dout1), .rx_done(done1), .rx_err(err1)
    );

    uart_rx #(.MAX_WORD_SIZE(8), .CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .rx(rx16), .rx_bits(rx_bits16),
        .dout(dout16), .rx_done(done16), .rx_err(err16)
    );

    typedef struct {
        bit         err;
        logic [7:0] dout;
        int         cyc;
    } ev_t;

    int         cyc = 0;
    ev_t        ev1[$];
    ev_t        ev16[$];
    bit         both_hi = 1'b0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] last_good1 = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done1 || err1)   ev1.push_back('{err1, dout1, cyc});
        if (done16 || err16) ev16.push_back('{err16, dout16, cyc});
        if ((done1 && err1) || (done16 && err16)) both_hi = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    function automatic int eff_bits(input int rxb);
        return (rxb == 0 || rxb > 8) ? 8 : rxb;
    endfunction

    function automatic logic [7:0] exp_word(input logic [7:0] w, input int rxb);
        int n;
        n = eff_bits(rxb);
        return w & 8'((1 << n) - 1);
    endfunction

    task automatic drive(input int which, input logic v);
        if (which == 1) rx1 = v;
        else            rx16 = v;
    endtask

    task automatic send(input int which, input logic [7:0] word, input int rxb,
                        input logic stop_v, input bit scramble, output int drive_cyc);
        int cpb;
        int n;
        cpb = (which == 1) ? 1 : 16;
        n   = eff_bits(rxb);
        if (which == 1) rx_bits1 = 6'(rxb);
        else            rx_bits16 = 6'(rxb);
        drive(which, 1'b0);
        drive_cyc = cyc;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            drive(which, word[i]);
            repeat (cpb) @(negedge clk);
        end
        drive(which, stop_v);
        if (scramble && which == 1) rx_bits1 = 6'($urandom);
        repeat (cpb) @(negedge clk);
        drive(which, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx1 = 1'b1; rx16 = 1'b1; rx_bits1 = 6'd8; rx_bits16 = 6'd8;
        repeat (3) @(negedge clk);
        checks += 6;
        if (dout1 !== 8'h00)  begin failures++; $display("FAIL reset_dout1 got=%h want=00", dout1); end
        if (done1 !== 1'b0)   begin failures++; $display("FAIL reset_done1 got=%b want=0", done1); end
        if (err1 !== 1'b0)    begin failures++; $display("FAIL reset_err1 got=%b want=0", err1); end
        if (dout16 !== 8'h00) begin failures++; $display("FAIL reset_dout16 got=%h want=00", dout16); end
        if (done16 !== 1'b0)  begin failures++; $display("FAIL reset_done16 got=%b want=0", done16); end
        if (err16 !== 1'b0)   begin failures++; $display("FAIL reset_err16 got=%b want=0", err16); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loopback();
        int c;
        ev1.delete();
        send(1, 8'hA5, 8, 1'b1, 1'b0, c);
        repeat (8) @(negedge clk);
        checks++;
        if (ev1.size() != 1) begin
            failures++; $display("FAIL loopback_count got=%0d want=1", ev1.size());
        end else begin
            checks += 3;
            if (ev1[0].err !== 1'b0)   begin failures++; $display("FAIL loopback_err got=%b want=0", ev1[0].err); end
            if (ev1[0].dout !== 8'hA5) begin failures++; $display("FAIL loopback_dout got=%h want=a5", ev1[0].dout); end
            if (ev1[0].cyc != c + 10 + SYNC_LAT) begin
                failures++; $display("FAIL loopback_latency got=%0d want=%0d", ev1[0].cyc, c + 10 + SYNC_LAT);
            end
        end
        last_good1 = 8'hA5;
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        ev1.delete();
        send(1, 8'h3C, 8, 1'b1, 1'b0, c0);
        send(1, 8'hC3, 8, 1'b1, 1'b0, c1);
        repeat (8) @(negedge clk);
        checks++;
        if (ev1.size() != 2) begin
            failures++; $display("FAIL b2b_count got=%0d want=2", ev1.size());
        end else begin
            checks += 4;
            if (ev1[0].err || ev1[0].dout !== 8'h3C) begin
                failures++; $display("FAIL b2b_first got=err%b/%h want=err0/3c", ev1[0].err, ev1[0].dout);
            end
            if (ev1[1].err || ev1[1].dout !== 8'hC3) begin
                failures++; $display("FAIL b2b_second got=err%b/%h want=err0/c3", ev1[1].err, ev1[1].dout);
            end
            if (ev1[0].cyc != c0 + 10 + SYNC_LAT) begin
                failures++; $display("FAIL b2b_lat0 got=%0d want=%0d", ev1[0].cyc, c0 + 10 + SYNC_LAT);
            end
            if (ev1[1].cyc != c1 + 10 + SYNC_LAT) begin
                failures++; $display("FAIL b2b_lat1 got=%0d want=%0d", ev1[1].cyc, c1 + 10 + SYNC_LAT);
            end
        end
        last_good1 = 8'hC3;
    endtask

    task automatic test_word_size();
        int c;
        send(1, 8'hF6, 5, 1'b1, 1'b0, c);
        repeat (8) @(negedge clk);
        checks += 2;
        if (dout1 !== 8'h16)       begin failures++; $display("FAIL size5_dout got=%h want=16", dout1); end
        if (dout1[7:5] !== 3'b000) begin failures++; $display("FAIL size5_upper got=%b want=000", dout1[7:5]); end
        send(1, 8'h9B, 0, 1'b1, 1'b0, c);
        repeat (8) @(negedge clk);
        checks++;
        if (dout1 !== 8'h9B) begin failures++; $display("FAIL size0_dout got=%h want=9b", dout1); end
        last_good1 = 8'h9B;
    endtask

    task automatic test_random();
        int         c, rxb, n;
        logic [7:0] w, expw;
        for (int k = 0; k < 20; k++) begin
            rxb  = int'($urandom_range(0, 12));
            w    = 8'($urandom);
            n    = eff_bits(rxb);
            expw = exp_word(w, rxb);
            ev1.delete();
            send(1, w, rxb, 1'b1, 1'b1, c);
            repeat (6 + int'($urandom_range(0, 3))) @(negedge clk);
            checks++;
            if (ev1.size() != 1 || ev1[0].err || ev1[0].dout !== expw || ev1[0].cyc != c + n + 2 + SYNC_LAT) begin
                failures++;
                $display("FAIL rand_frame%0d n=%0d got_count=%0d got=%h want=%h", k, n, ev1.size(),
                         (ev1.size() > 0) ? ev1[0].dout : 8'hxx, expw);
            end
            last_good1 = expw;
        end
    endtask

    task automatic test_framing();
        int c;
        ev1.delete();
        send(1, 8'hFF, 8, 1'b0, 1'b0, c);
        repeat (8) @(negedge clk);
        checks += 2;
        if (ev1.size() != 1 || !ev1[0].err) begin
            failures++; $display("FAIL framing_event got_count=%0d want=1 err", ev1.size());
        end else if (ev1[0].cyc != c + 10 + SYNC_LAT) begin
            failures++; $display("FAIL framing_latency got=%0d want=%0d", ev1[0].cyc, c + 10 + SYNC_LAT);
        end
        if (dout1 !== last_good1) begin failures++; $display("FAIL framing_dout_held got=%h want=%h", dout1, last_good1); end
    endtask

    task automatic test_break();
        int nerr, ndone;
        ev1.delete();
        rx_bits1 = 6'd8;
        rx1 = 1'b0;
        repeat (40) @(negedge clk);
        rx1 = 1'b1;
        repeat (10) @(negedge clk);
        nerr = 0; ndone = 0;
        foreach (ev1[i]) begin
            if (ev1[i].err) nerr++;
            else            ndone++;
        end
        checks += 3;
        if (nerr != 4)  begin failures++; $display("FAIL break_errs got=%0d want=4", nerr); end
        if (ndone != 0) begin failures++; $display("FAIL break_dones got=%0d want=0", ndone); end
        if (dout1 !== last_good1) begin failures++; $display("FAIL break_dout got=%h want=%h", dout1, last_good1); end
    endtask

    task automatic test_glitch16();
        int c;
        ev16.delete();
        rx16 = 1'b0;
        repeat (3) @(negedge clk);
        rx16 = 1'b1;
        repeat (40) @(negedge clk);
        checks += 2;
        if (ev16.size() != 0) begin failures++; $display("FAIL glitch_strobe got=%0d want=0", ev16.size()); end
        if (dout16 !== 8'h00) begin failures++; $display("FAIL glitch_dout got=%h want=00", dout16); end
        send(16, 8'h5A, 8, 1'b1, 1'b0, c);
        repeat (20) @(negedge clk);
        checks += 2;
        if (ev16.size() != 1 || ev16[0].err || ev16[0].dout !== 8'h5A) begin
            failures++; $display("FAIL cpb16_frame got_count=%0d want=1 done 5a", ev16.size());
        end
        if (dout16 !== 8'h5A) begin failures++; $display("FAIL cpb16_dout got=%h want=5a", dout16); end
    endtask

    task automatic test_reset_mid();
        int c;
        ev1.delete();
        rx_bits1 = 6'd8;
        rx1 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx1 = 1'b1;
            @(negedge clk);
        end
        rx1 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (dout1 !== 8'h00)  begin failures++; $display("FAIL midrst_dout1 got=%h want=00", dout1); end
        if (done1 !== 1'b0 || err1 !== 1'b0) begin
            failures++; $display("FAIL midrst_strobes got=%b%b want=00", done1, err1);
        end
        if (dout16 !== 8'h00) begin failures++; $display("FAIL midrst_dout16 got=%h want=00", dout16); end
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        if (ev1.size() != 0) begin failures++; $display("FAIL midrst_discard got=%0d want=0", ev1.size()); end
        send(1, 8'h81, 8, 1'b1, 1'b0, c);
        repeat (8) @(negedge clk);
        checks++;
        if (ev1.size() != 1 || ev1[0].err || ev1[0].dout !== 8'h81) begin
            failures++; $display("FAIL midrst_next got_count=%0d want=1 done 81", ev1.size());
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_hi !== 1'b0) begin failures++; $display("FAIL done_err_overlap got=%b want=0", both_hi); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_word_size();
        test_random();
        test_framing();
        test_break();
        test_glitch16();
        test_reset_mid();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
